// File: rtl/pagerank_pkg.sv
// Shared types for the PageRank iteration scheduler: FSM states and dispatch phase encoding.
package pagerank_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCATTER = 3'd1,
        S_GATHER  = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } sched_state_t;

    typedef enum logic {
        SCATTER_PHASE = 1'b0,
        GATHER_PHASE  = 1'b1
    } phase_t;

endpackage

// File: rtl/pagerank_thread_picker.sv
// Lowest-index idle thread finder over the registered busy vector.
module pagerank_thread_picker #(
    parameter int unsigned NUM_HW_THREADS = 4,
    parameter int unsigned TID_W          = 2
) (
    input  logic [NUM_HW_THREADS-1:0] thread_busy,
    output logic                      found,
    output logic [TID_W-1:0]          tid
);

    // Scan from the top so the lowest idle index is the last one written.
    always_comb begin
        found = 1'b0;
        tid   = '0;
        for (int i = int'(NUM_HW_THREADS) - 1; i >= 0; i--) begin
            if (!thread_busy[i]) begin
                found = 1'b1;
                tid   = TID_W'(i);
            end
        end
    end

endmodule

// File: rtl/pagerank_iteration_scheduler.sv
// Sequences scatter/gather phases of the PageRank engine across iterations and
// shares the hardware thread array between partitions.
module pagerank_iteration_scheduler
    import pagerank_pkg::*;
#(
    parameter int unsigned NUM_PARTITIONS = 4,
    parameter int unsigned NUM_HW_THREADS = 4,
    parameter int unsigned MAX_ITER       = 64,
    parameter int unsigned PID_W          = $clog2(NUM_PARTITIONS + 1),
    parameter int unsigned TID_W          = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1,
    parameter int unsigned ITER_W         = $clog2(MAX_ITER + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      pagerank_enable,
    output logic                      dispatch_valid,
    output logic [TID_W-1:0]          dispatch_thread,
    output logic [PID_W-1:0]          dispatch_partition,
    output logic                      dispatch_phase,
    input  logic [NUM_HW_THREADS-1:0] thread_done,
    input  logic [NUM_HW_THREADS-1:0] thread_converged,
    output logic [ITER_W-1:0]         iteration,
    output logic                      busy,
    output logic                      pagerank_complete,
    output logic                      converged,
    output logic                      protocol_error
);

    localparam logic [PID_W-1:0]  PID_END  = PID_W'(NUM_PARTITIONS);
    localparam logic [ITER_W-1:0] ITER_END = ITER_W'(MAX_ITER);

    sched_state_t              state;
    sched_state_t              state_nxt;
    logic [NUM_HW_THREADS-1:0] thread_busy;
    logic [NUM_HW_THREADS-1:0] thread_busy_nxt;
    logic [PID_W-1:0]          next_pid;
    logic [PID_W-1:0]          pid_nxt;
    logic                      conv_acc;
    logic                      acc_nxt;
    logic [ITER_W-1:0]         iter_nxt;
    logic                      conv_nxt;
    logic                      perr_nxt;
    logic                      pick_found;
    logic [TID_W-1:0]          pick_tid;
    logic                      in_phase;
    logic                      phase_done;
    phase_t                    phase;

    pagerank_thread_picker #(
        .NUM_HW_THREADS (NUM_HW_THREADS),
        .TID_W          (TID_W)
    ) u_picker (
        .thread_busy (thread_busy),
        .found       (pick_found),
        .tid         (pick_tid)
    );

    assign in_phase          = (state == S_SCATTER) || (state == S_GATHER);
    assign phase_done        = (next_pid == PID_END) && (thread_busy == '0);
    assign busy              = in_phase || (state == S_CHECK);
    assign pagerank_complete = (state == S_DONE);

    // Next-state, bookkeeping and combinational dispatch decode.
    always_comb begin
        state_nxt          = state;
        thread_busy_nxt    = thread_busy;
        pid_nxt            = next_pid;
        acc_nxt            = conv_acc;
        iter_nxt           = iteration;
        conv_nxt           = converged;
        perr_nxt           = protocol_error;
        phase              = (state == S_GATHER) ? GATHER_PHASE : SCATTER_PHASE;
        dispatch_valid     = 1'b0;
        dispatch_thread    = '0;
        dispatch_partition = '0;
        dispatch_phase     = 1'b0;

        // Completions; done on an idle thread only flags an error once a run has started.
        for (int i = 0; i < int'(NUM_HW_THREADS); i++) begin
            if (thread_done[i]) begin
                if (thread_busy[i]) begin
                    thread_busy_nxt[i] = 1'b0;
                    if (state == S_GATHER) begin
                        acc_nxt = acc_nxt & thread_converged[i];
                    end
                end else if (state != S_IDLE) begin
                    perr_nxt = 1'b1;
                end
            end
        end

        if (in_phase && (next_pid < PID_END) && pick_found) begin
            dispatch_valid     = 1'b1;
            dispatch_thread    = pick_tid;
            dispatch_partition = next_pid;
            dispatch_phase     = phase;
            pid_nxt            = next_pid + PID_W'(1);
            for (int i = 0; i < int'(NUM_HW_THREADS); i++) begin
                if (pick_tid == TID_W'(i)) begin
                    thread_busy_nxt[i] = 1'b1;
                end
            end
        end

        case (state)
            S_IDLE: begin
                if (pagerank_enable) begin
                    state_nxt = S_SCATTER;
                    pid_nxt   = '0;
                    acc_nxt   = 1'b1;
                    iter_nxt  = '0;
                    conv_nxt  = 1'b0;
                    perr_nxt  = 1'b0;
                end
            end
            S_SCATTER: begin
                if (phase_done) begin
                    state_nxt = S_GATHER;
                    pid_nxt   = '0;
                end
            end
            S_GATHER: begin
                if (phase_done) begin
                    state_nxt = S_CHECK;
                    pid_nxt   = '0;
                end
            end
            S_CHECK: begin
                if (iteration != ITER_END) begin
                    iter_nxt = iteration + ITER_W'(1);
                end
                if (conv_acc) begin
                    state_nxt = S_DONE;
                    conv_nxt  = 1'b1;
                end else if (iter_nxt == ITER_END) begin
                    state_nxt = S_DONE;
                    conv_nxt  = 1'b0;
                end else begin
                    state_nxt = S_SCATTER;
                    pid_nxt   = '0;
                    acc_nxt   = 1'b1;
                end
            end
            S_DONE: begin
                if (!pagerank_enable) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            thread_busy    <= '0;
            next_pid       <= '0;
            conv_acc       <= 1'b1;
            iteration      <= '0;
            converged      <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            state          <= state_nxt;
            thread_busy    <= thread_busy_nxt;
            next_pid       <= pid_nxt;
            conv_acc       <= acc_nxt;
            iteration      <= iter_nxt;
            converged      <= conv_nxt;
            protocol_error <= perr_nxt;
        end
    end

endmodule

// File: tb/tb_pagerank_iteration_scheduler.sv
// Scoreboard bench: two schedulers (4 and 2 threads) driven by randomized thread responders.
module tb_pagerank_iteration_scheduler;

    localparam int unsigned P      = 4;
    localparam int unsigned MAXI   = 8;
    localparam int unsigned NI     = 2;
    localparam int unsigned IT_CYC = 2 * (P + 2) + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b0;

    logic       dv0, dph0, busy0, cpl0, conv0, perr0;
    logic [1:0] dt0;
    logic [2:0] dp0;
    logic [3:0] it0;
    logic [3:0] td0 = '0;
    logic [3:0] tc0 = '0;

    logic       dv1, dph1, busy1, cpl1, conv1, perr1;
    logic [0:0] dt1;
    logic [2:0] dp1;
    logic [3:0] it1;
    logic [1:0] td1 = '0;
    logic [1:0] tc1 = '0;

    int vectors     = 0;
    int miscompares = 0;
    int nt [NI]     = '{4, 2};
    bit model_on    = 1'b0;
    int cyc         = 0;
    int lat_lo      = 1;
    int lat_hi      = 1;
    int start_cyc   = 0;

    bit bbusy [NI][4];
    bit drove [NI][4];
    int cnt   [NI][4];
    int tpid  [NI][4];
    int tph   [NI][4];
    int titer [NI][4];
    int th    [NI][P];
    int nd    [NI];
    bit fin_pend [NI];
    int fin_iter [NI];
    int fin_conv [NI];
    bit chk_lat  [NI];
    int expq0[$];
    int expq1[$];

    always #5 clock = ~clock;

    pagerank_iteration_scheduler #(
        .NUM_PARTITIONS (P),
        .NUM_HW_THREADS (4),
        .MAX_ITER       (MAXI)
    ) u_dut0 (
        .clock              (clock),
        .reset              (reset),
        .pagerank_enable    (en),
        .dispatch_valid     (dv0),
        .dispatch_thread    (dt0),
        .dispatch_partition (dp0),
        .dispatch_phase     (dph0),
        .thread_done        (td0),
        .thread_converged   (tc0),
        .iteration          (it0),
        .busy               (busy0),
        .pagerank_complete  (cpl0),
        .converged          (conv0),
        .protocol_error     (perr0)
    );

    pagerank_iteration_scheduler #(
        .NUM_PARTITIONS (P),
        .NUM_HW_THREADS (2),
        .MAX_ITER       (MAXI)
    ) u_dut1 (
        .clock              (clock),
        .reset              (reset),
        .pagerank_enable    (en),
        .dispatch_valid     (dv1),
        .dispatch_thread    (dt1),
        .dispatch_partition (dp1),
        .dispatch_phase     (dph1),
        .thread_done        (td1),
        .thread_converged   (tc1),
        .iteration          (it1),
        .busy               (busy1),
        .pagerank_complete  (cpl1),
        .converged          (conv1),
        .protocol_error     (perr1)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input int act);
        vectors++;
        miscompares++;
        $display("FAIL %s: observed %0d (t=%0t)", name, act, $time);
    endtask

    task automatic get_out(input int u, output int v, output int t, output int pid, output int ph,
                           output int itv, output int cp, output int cv, output int pe, output int bz);
        if (u == 0) begin
            v = int'(dv0); t = int'(dt0); pid = int'(dp0); ph = int'(dph0);
            itv = int'(it0); cp = int'(cpl0); cv = int'(conv0); pe = int'(perr0); bz = int'(busy0);
        end else begin
            v = int'(dv1); t = int'(dt1); pid = int'(dp1); ph = int'(dph1);
            itv = int'(it1); cp = int'(cpl1); cv = int'(conv1); pe = int'(perr1); bz = int'(busy1);
        end
    endtask

    task automatic set_done(input int u, input int i, input logic c);
        if (u == 0) begin
            td0[i] = 1'b1;
            tc0[i] = c;
        end else begin
            td1[i] = 1'b1;
            tc1[i] = c;
        end
    endtask

    function automatic int q_size(input int u);
        return (u == 0) ? expq0.size() : expq1.size();
    endfunction

    task automatic q_push(input int u, input int item);
        if (u == 0) expq0.push_back(item);
        else expq1.push_back(item);
    endtask

    task automatic q_pop(input int u, output int item, output bit ok);
        item = 0;
        ok   = (q_size(u) > 0);
        if (ok) begin
            if (u == 0) item = expq0.pop_front();
            else item = expq1.pop_front();
        end
    endtask

    // Thread responder plus monitor for one scheduler; runs once per cycle after the edge.
    task automatic step(input int u);
        int v, t, pid, ph, itv, cp, cv, pe, bz, low, item;
        bit ok;
        logic c;
        get_out(u, v, t, pid, ph, itv, cp, cv, pe, bz);
        for (int i = 0; i < nt[u]; i++) begin
            if (drove[u][i]) begin
                bbusy[u][i] = 1'b0;
                drove[u][i] = 1'b0;
            end
        end
        for (int i = 0; i < nt[u]; i++) begin
            if (bbusy[u][i] && cnt[u][i] > 0) begin
                cnt[u][i]--;
                if (cnt[u][i] == 0) begin
                    if (tph[u][i] == 1) c = (titer[u][i] >= th[u][tpid[u][i]]);
                    else c = 1'($urandom_range(1, 0));
                    set_done(u, i, c);
                    drove[u][i] = 1'b1;
                end
            end
        end
        low = -1;
        for (int i = nt[u] - 1; i >= 0; i--) begin
            if (!bbusy[u][i]) low = i;
        end
        if (v != 0) begin
            chk($sformatf("dispatch_thread[u%0d]", u), t, low);
            q_pop(u, item, ok);
            if (!ok) begin
                fail($sformatf("extra_dispatch[u%0d] partition", u), pid);
            end else begin
                chk($sformatf("dispatch_phase[u%0d]", u), ph, item / 256);
                chk($sformatf("dispatch_partition[u%0d]", u), pid, item % 256);
            end
            if (t >= 0 && t < nt[u]) begin
                bbusy[u][t] = 1'b1;
                cnt[u][t]   = int'($urandom_range(lat_hi, lat_lo));
                tpid[u][t]  = ok ? (item % 256) : 0;
                tph[u][t]   = ok ? (item / 256) : 0;
                titer[u][t] = nd[u] / int'(2 * P);
            end
            nd[u]++;
        end else if ((nd[u] % int'(P)) != 0 && q_size(u) > 0 && low >= 0) begin
            chk($sformatf("dispatch_stall[u%0d]", u), v, 1);
        end
        if (cp != 0 && fin_pend[u]) begin
            fin_pend[u] = 1'b0;
            chk($sformatf("iteration[u%0d]", u), itv, fin_iter[u]);
            chk($sformatf("converged[u%0d]", u), cv, fin_conv[u]);
            chk($sformatf("missing_dispatches[u%0d]", u), q_size(u), 0);
            chk($sformatf("protocol_error[u%0d]", u), pe, 0);
            chk($sformatf("busy_in_done[u%0d]", u), bz, 0);
            if (chk_lat[u]) chk($sformatf("run_latency[u%0d]", u), cyc - start_cyc, fin_iter[u] * int'(IT_CYC) + 1);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (model_on) begin
                td0 = '0; tc0 = '0; td1 = '0; tc1 = '0;
                step(0);
                step(1);
            end
        end
    end

    // Reference model: stop at the first iteration where every partition has converged, else at the cap.
    task automatic start_run(input int lo, input int hi, input bit rnd_th, input int stubborn);
        bit all;
        lat_lo = lo;
        lat_hi = hi;
        for (int u = 0; u < int'(NI); u++) begin
            for (int p = 0; p < int'(P); p++) begin
                if (rnd_th) th[u][p] = int'($urandom_range(9, 0));
                else th[u][p] = (p == stubborn) ? 1000 : 0;
            end
            fin_iter[u] = int'(MAXI);
            fin_conv[u] = 0;
            for (int k = 0; k < int'(MAXI); k++) begin
                all = 1'b1;
                for (int p = 0; p < int'(P); p++) if (k < th[u][p]) all = 1'b0;
                if (all) begin
                    fin_iter[u] = k + 1;
                    fin_conv[u] = 1;
                    break;
                end
            end
            for (int k = 0; k < fin_iter[u]; k++)
                for (int ph = 0; ph < 2; ph++)
                    for (int p = 0; p < int'(P); p++) q_push(u, ph * 256 + p);
            nd[u]       = 0;
            fin_pend[u] = 1'b1;
            chk_lat[u]  = (lo == 1 && hi == 1 && nt[u] >= int'(P));
        end
        start_cyc = cyc;
        en        = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((fin_pend[0] || fin_pend[1]) && n < 3000) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (fin_pend[0] || fin_pend[1]) begin
            fail("run_timeout cycles", n);
            fin_pend[0] = 1'b0;
            fin_pend[1] = 1'b0;
        end
    endtask

    task automatic end_run();
        en = 1'b0;
        @(posedge clock);
        #2;
        chk("complete_after_drop[u0]", int'(cpl0), 0);
        chk("complete_after_drop[u1]", int'(cpl1), 0);
    endtask

    task automatic check_reset_outputs();
        int v, t, pid, ph, itv, cp, cv, pe, bz;
        for (int u = 0; u < int'(NI); u++) begin
            get_out(u, v, t, pid, ph, itv, cp, cv, pe, bz);
            chk($sformatf("rst_dispatch_valid[u%0d]", u), v, 0);
            chk($sformatf("rst_dispatch_thread[u%0d]", u), t, 0);
            chk($sformatf("rst_dispatch_partition[u%0d]", u), pid, 0);
            chk($sformatf("rst_dispatch_phase[u%0d]", u), ph, 0);
            chk($sformatf("rst_iteration[u%0d]", u), itv, 0);
            chk($sformatf("rst_busy[u%0d]", u), bz, 0);
            chk($sformatf("rst_complete[u%0d]", u), cp, 0);
            chk($sformatf("rst_converged[u%0d]", u), cv, 0);
            chk($sformatf("rst_protocol_error[u%0d]", u), pe, 0);
        end
    endtask

    task automatic flush_model();
        expq0.delete();
        expq1.delete();
        for (int u = 0; u < int'(NI); u++) begin
            nd[u]       = 0;
            fin_pend[u] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                bbusy[u][i] = 1'b0;
                drove[u][i] = 1'b0;
                cnt[u][i]   = 0;
            end
        end
        td0 = '0; tc0 = '0; td1 = '0; tc1 = '0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #2;
        check_reset_outputs();
        reset    = 1'b0;
        model_on = 1'b1;

        // Single-cycle responders, everything converges in the first iteration.
        start_run(1, 1, 1'b0, -1);
        wait_done();
        end_run();

        // Three-cycle responders: the two-thread scheduler must reuse freed threads.
        start_run(3, 3, 1'b0, -1);
        wait_done();
        end_run();

        // Partition 3 never converges: run ends at the iteration cap.
        start_run(1, 1, 1'b0, 3);
        wait_done();
        end_run();

        // Reset part-way through the first gather phase.
        start_run(1, 3, 1'b0, 3);
        n = 0;
        while (nd[0] < int'(P) + 2 && n < 500) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (nd[0] < int'(P) + 2) fail("reach_gather_timeout dispatches", nd[0]);
        model_on = 1'b0;
        reset    = 1'b1;
        en       = 1'b0;
        @(posedge clock);
        #2;
        check_reset_outputs();
        reset = 1'b0;
        flush_model();
        model_on = 1'b1;
        start_run(1, 1, 1'b0, -1);
        wait_done();

        // Spurious completion on idle thread 2 while parked in DONE.
        @(posedge clock);
        #2;
        td0[2] = 1'b1;
        @(posedge clock);
        #2;
        chk("spurious_perr[u0]", int'(perr0), 1);
        chk("spurious_complete_held[u0]", int'(cpl0), 1);
        chk("spurious_iteration_held[u0]", int'(it0), fin_iter[0]);
        chk("spurious_perr[u1]", int'(perr1), 0);
        @(posedge clock);
        #2;
        chk("perr_sticky[u0]", int'(perr0), 1);
        en = 1'b0;
        @(posedge clock);
        #2;
        chk("perr_sticky_idle[u0]", int'(perr0), 1);
        chk("complete_after_drop[u0]", int'(cpl0), 0);
        start_run(1, 1, 1'b0, -1);
        @(posedge clock);
        #2;
        chk("perr_cleared_on_start[u0]", int'(perr0), 0);
        chk("busy_after_start[u0]", int'(busy0), 1);
        wait_done();
        end_run();

        // Randomized latencies and convergence profiles.
        for (int r = 0; r < 8; r++) begin
            start_run(1, 5, 1'b1, -1);
            wait_done();
            end_run();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
